// File: rtl/call_return_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | call_return_ctrl_if                                                        |
// | Bundle between the decode/stack side and the PC / call-return sequencer.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface call_return_ctrl_if;
    logic        is_call;
    logic        is_callw;
    logic        is_goto;
    logic        is_bra;
    logic        is_brw;
    logic        is_return;
    logic        is_retlw;
    logic        is_retfie;
    logic        skip;
    logic [10:0] k11;
    logic [8:0]  bra_off;
    logic [7:0]  w;
    logic [2:0]  pclath;
    logic        irq;
    logic        gie_wr;
    logic        gie_din;
    logic        flag_clr;
    logic [10:0] stack_out;
    logic [10:0] pc;
    logic        flush;
    logic        push;
    logic        pop;
    logic [10:0] stack_in;
    logic        gie;
    logic        stkovf;
    logic        stkunf;

    modport master (
        output is_call, is_callw, is_goto, is_bra, is_brw,
        output is_return, is_retlw, is_retfie, skip,
        output k11, bra_off, w, pclath, irq, gie_wr, gie_din, flag_clr, stack_out,
        input  pc, flush, push, pop, stack_in, gie, stkovf, stkunf
    );

    modport slave (
        input  is_call, is_callw, is_goto, is_bra, is_brw,
        input  is_return, is_retlw, is_retfie, skip,
        input  k11, bra_off, w, pclath, irq, gie_wr, gie_din, flag_clr, stack_out,
        output pc, flush, push, pop, stack_in, gie, stkovf, stkunf
    );
endinterface
`default_nettype wire

// File: rtl/call_return_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | call_return_ctrl                                                           |
// | Next-fetch PC, return-stack push/pop, interrupt entry and stack faults.    |
// | Option macro: STACK_FAULT_RESET_EN (stack fault forces a core restart).    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module call_return_ctrl #(
    parameter logic [10:0] RESET_VEC = 11'h000,
    parameter logic [10:0] IRQ_VEC   = 11'h004
) (
    input  logic              clk,
    input  logic              rst,
    call_return_ctrl_if.slave bus
);
    localparam logic [4:0] c_MAX_DEPTH = 5'd16;

    logic [10:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        gie_q, gie_d;
    logic        stkovf_q, stkovf_d;
    logic        stkunf_q, stkunf_d;
    logic [4:0]  depth_q, depth_d;

    logic w_exec;
    logic w_call_any;
    logic w_ret_any;
    logic w_xfer;
    logic w_irq_take;
    logic w_push_req;
    logic w_pop_req;
    logic w_ovf;
    logic w_unf;
    logic w_push;
    logic w_pop;

    // A flushed slot holds a discarded fetch: no decode, no interrupt sampling.
    assign w_exec     = ~flush_q;
    assign w_call_any = w_exec & (bus.is_call | bus.is_callw);
    assign w_ret_any  = w_exec & (bus.is_return | bus.is_retlw | bus.is_retfie);
    assign w_xfer     = w_call_any | w_ret_any
                      | (w_exec & (bus.is_goto | bus.is_bra | bus.is_brw));
    assign w_irq_take = w_exec & bus.irq & gie_q & ~w_xfer;
    assign w_push_req = w_call_any | w_irq_take;
    assign w_pop_req  = w_ret_any;
    assign w_ovf      = w_push_req & (depth_q == c_MAX_DEPTH);
    assign w_unf      = w_pop_req & (depth_q == 5'd0);

`ifdef STACK_FAULT_RESET_EN
    logic w_fault;
    assign w_fault = w_ovf | w_unf;
    assign w_push  = w_push_req & ~w_fault & ~rst;
    assign w_pop   = w_pop_req & ~w_fault & ~rst;
`else
    assign w_push  = w_push_req & ~rst;
    assign w_pop   = w_pop_req & ~rst;
`endif

    assign bus.push     = w_push;
    assign bus.pop      = w_pop;
    assign bus.stack_in = w_push ? pc_q : 11'h000;
    assign bus.pc       = pc_q;
    assign bus.flush    = flush_q;
    assign bus.gie      = gie_q;
    assign bus.stkovf   = stkovf_q;
    assign bus.stkunf   = stkunf_q;

    always_comb begin
        pc_d     = pc_q + 11'd1;
        flush_d  = 1'b0;
        gie_d    = gie_q;
        depth_d  = depth_q;
        stkovf_d = stkovf_q;
        stkunf_d = stkunf_q;

        if (bus.flag_clr) begin
            stkovf_d = 1'b0;
            stkunf_d = 1'b0;
        end

        if (w_exec) begin
            if (bus.gie_wr) begin
                gie_d = bus.gie_din;
            end
            if (bus.skip) begin
                flush_d = 1'b1;
            end
            if (bus.is_call) begin
                pc_d    = bus.k11;
                flush_d = 1'b1;
            end else if (bus.is_callw) begin
                pc_d    = {bus.pclath, bus.w};
                flush_d = 1'b1;
            end else if (bus.is_goto) begin
                pc_d    = bus.k11;
                flush_d = 1'b1;
            end else if (bus.is_bra) begin
                pc_d    = pc_q + {{2{bus.bra_off[8]}}, bus.bra_off};
                flush_d = 1'b1;
            end else if (bus.is_brw) begin
                pc_d    = pc_q + {3'b000, bus.w};
                flush_d = 1'b1;
            end else if (bus.is_return | bus.is_retlw) begin
                pc_d    = bus.stack_out;
                flush_d = 1'b1;
            end else if (bus.is_retfie) begin
                pc_d    = bus.stack_out;
                flush_d = 1'b1;
                gie_d   = 1'b1;
            end else if (w_irq_take) begin
                // The ordinary op in this slot retires; its successor becomes the return address.
                pc_d    = IRQ_VEC;
                flush_d = 1'b1;
                gie_d   = 1'b0;
            end
        end

        if (w_push_req & ~w_ovf) begin
            depth_d = depth_q + 5'd1;
        end
        if (w_pop_req & ~w_unf) begin
            depth_d = depth_q - 5'd1;
        end
        if (w_ovf) begin
            stkovf_d = 1'b1;
        end
        if (w_unf) begin
            stkunf_d = 1'b1;
        end

`ifdef STACK_FAULT_RESET_EN
        if (w_fault) begin
            pc_d    = RESET_VEC;
            flush_d = 1'b1;
            depth_d = 5'd0;
            gie_d   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_VEC;
            flush_q  <= 1'b1;
            gie_q    <= 1'b0;
            depth_q  <= 5'd0;
            stkovf_q <= 1'b0;
            stkunf_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            flush_q  <= flush_d;
            gie_q    <= gie_d;
            depth_q  <= depth_d;
            stkovf_q <= stkovf_d;
            stkunf_q <= stkunf_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_call_return_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_call_return_ctrl                                                        |
// | Directed stimulus, per-cycle behavioural model compare, literal pins.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_call_return_ctrl;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    call_return_ctrl_if bus();

    call_return_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what the sequencer must hold this cycle.
    int m_pc;
    int m_depth;
    bit m_flush;
    bit m_gie;
    bit m_ovf;
    bit m_unf;

    always @(negedge clk) begin : p_model
        bit exec, xfer, take_irq, e_push, e_pop, f_ovf, f_unf;
        int n_pc, off, n_depth;
        bit n_flush, n_gie, n_ovf, n_unf;

        if (rst) begin
            m_pc = 0; m_flush = 1'b1; m_gie = 1'b0;
            m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
        end

        exec     = !m_flush;
        xfer     = exec && (bus.is_call || bus.is_callw || bus.is_goto || bus.is_bra ||
                            bus.is_brw || bus.is_return || bus.is_retlw || bus.is_retfie);
        take_irq = exec && bus.irq && m_gie && !xfer;
        e_push   = !rst && ((exec && (bus.is_call || bus.is_callw)) || take_irq);
        e_pop    = !rst && exec && (bus.is_return || bus.is_retlw || bus.is_retfie);
        f_ovf    = e_push && (m_depth == 16);
        f_unf    = e_pop && (m_depth == 0);
`ifdef STACK_FAULT_RESET_EN
        if (f_ovf || f_unf) begin
            e_push = 1'b0;
            e_pop  = 1'b0;
        end
`endif

        chk("model.pc", {21'b0, bus.pc}, m_pc);
        chk("model.flush", {31'b0, bus.flush}, {31'b0, m_flush});
        chk("model.gie", {31'b0, bus.gie}, {31'b0, m_gie});
        chk("model.stkovf", {31'b0, bus.stkovf}, {31'b0, m_ovf});
        chk("model.stkunf", {31'b0, bus.stkunf}, {31'b0, m_unf});
        chk("model.push", {31'b0, bus.push}, {31'b0, e_push});
        chk("model.pop", {31'b0, bus.pop}, {31'b0, e_pop});
        if (e_push) chk("model.stack_in", {21'b0, bus.stack_in}, m_pc);

        if (!rst) begin
            n_pc    = (m_pc + 1) % 2048;
            n_flush = 1'b0;
            n_gie   = m_gie;
            if (exec) begin
                if (bus.gie_wr) n_gie = bus.gie_din;
                if (bus.skip) n_flush = 1'b1;
                if (xfer) n_flush = 1'b1;
                if (bus.is_call || bus.is_goto) n_pc = int'(bus.k11);
                else if (bus.is_callw) n_pc = int'(bus.pclath) * 256 + int'(bus.w);
                else if (bus.is_bra) begin
                    off  = bus.bra_off[8] ? int'(bus.bra_off) - 512 : int'(bus.bra_off);
                    n_pc = ((m_pc + off) % 2048 + 2048) % 2048;
                end
                else if (bus.is_brw) n_pc = (m_pc + int'(bus.w)) % 2048;
                else if (bus.is_return || bus.is_retlw) n_pc = int'(bus.stack_out);
                else if (bus.is_retfie) begin
                    n_pc  = int'(bus.stack_out);
                    n_gie = 1'b1;
                end
                else if (take_irq) begin
                    n_pc    = 4;
                    n_flush = 1'b1;
                    n_gie   = 1'b0;
                end
            end
            n_depth = m_depth;
            if (f_ovf || f_unf) n_depth = m_depth;
            else if ((exec && (bus.is_call || bus.is_callw)) || take_irq) n_depth = m_depth + 1;
            else if (exec && (bus.is_return || bus.is_retlw || bus.is_retfie)) n_depth = m_depth - 1;
            n_ovf = f_ovf ? 1'b1 : (bus.flag_clr ? 1'b0 : m_ovf);
            n_unf = f_unf ? 1'b1 : (bus.flag_clr ? 1'b0 : m_unf);
`ifdef STACK_FAULT_RESET_EN
            if (f_ovf || f_unf) begin
                n_pc = 0; n_flush = 1'b1; n_depth = 0; n_gie = 1'b0;
            end
`endif
            m_pc = n_pc; m_flush = n_flush; m_gie = n_gie;
            m_depth = n_depth; m_ovf = n_ovf; m_unf = n_unf;
        end
    end

    task automatic clear_ops();
        bus.is_call = 0; bus.is_callw = 0; bus.is_goto = 0; bus.is_bra = 0;
        bus.is_brw = 0; bus.is_return = 0; bus.is_retlw = 0; bus.is_retfie = 0;
        bus.skip = 0; bus.gie_wr = 0; bus.gie_din = 0; bus.flag_clr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_ops();
    endtask

    task automatic do_goto(input logic [10:0] a);
        bus.is_goto = 1; bus.k11 = a;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        clear_ops();
        bus.k11 = 0; bus.bra_off = 0; bus.w = 0; bus.pclath = 0;
        bus.irq = 0; bus.stack_out = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.pc", {21'b0, bus.pc}, 32'h000);
        chk("rst.flush", {31'b0, bus.flush}, 32'd1);
        chk("rst.gie", {31'b0, bus.gie}, 32'd0);
        chk("rst.push", {31'b0, bus.push}, 32'd0);
        chk("rst.pop", {31'b0, bus.pop}, 32'd0);
        chk("rst.stack_in", {21'b0, bus.stack_in}, 32'h000);
        chk("rst.flags", {30'b0, bus.stkovf, bus.stkunf}, 32'd0);
        rst = 1'b0;

        chk("run.pc0", {21'b0, bus.pc}, 32'h000);
        tick(); chk("run.pc1", {21'b0, bus.pc}, 32'h001);
        chk("run.flush1", {31'b0, bus.flush}, 32'd0);
        tick(); chk("run.pc2", {21'b0, bus.pc}, 32'h002);
        tick(); chk("run.pc3", {21'b0, bus.pc}, 32'h003);

        do_goto(11'h010);
        chk("goto.pc", {21'b0, bus.pc}, 32'h011);
        bus.is_call = 1; bus.k11 = 11'h123;
        #1;
        chk("call.push", {31'b0, bus.push}, 32'd1);
        chk("call.stack_in", {21'b0, bus.stack_in}, 32'h011);
        tick();
        chk("call.pc", {21'b0, bus.pc}, 32'h123);
        chk("call.flush", {31'b0, bus.flush}, 32'd1);
        tick();
        bus.is_return = 1; bus.stack_out = 11'h011;
        #1;
        chk("ret.pop", {31'b0, bus.pop}, 32'd1);
        tick();
        chk("ret.pc", {21'b0, bus.pc}, 32'h011);
        tick();

        bus.skip = 1;
        tick();
        chk("skip.flush", {31'b0, bus.flush}, 32'd1);
        chk("skip.pc", {21'b0, bus.pc}, 32'h013);
        tick();

        do_goto(11'h004);
        bus.is_bra = 1; bus.bra_off = 9'h1FE;
        tick();
        chk("bra.pc", {21'b0, bus.pc}, 32'h003);
        tick();

        do_goto(11'h7FE);
        bus.is_brw = 1; bus.w = 8'hFF;
        tick();
        chk("brw.pc", {21'b0, bus.pc}, 32'h0FE);
        tick();

        bus.is_callw = 1; bus.pclath = 3'b101; bus.w = 8'h3C;
        #1;
        chk("callw.stack_in", {21'b0, bus.stack_in}, 32'h0FF);
        tick();
        chk("callw.pc", {21'b0, bus.pc}, 32'h53C);
        tick();
        bus.is_retlw = 1; bus.stack_out = 11'h0FF;
        tick();
        chk("retlw.pc", {21'b0, bus.pc}, 32'h0FF);
        tick();

        bus.gie_wr = 1; bus.gie_din = 1;
        tick();
        chk("giewr.gie", {31'b0, bus.gie}, 32'd1);
        bus.is_goto = 1; bus.k11 = 11'h050; bus.irq = 1;
        #1;
        chk("irq.defer", {31'b0, bus.push}, 32'd0);
        tick();
        chk("irq.goto_pc", {21'b0, bus.pc}, 32'h050);
        tick();
        #1;
        chk("irq.push", {31'b0, bus.push}, 32'd1);
        chk("irq.stack_in", {21'b0, bus.stack_in}, 32'h051);
        tick();
        chk("irq.pc", {21'b0, bus.pc}, 32'h004);
        chk("irq.gie", {31'b0, bus.gie}, 32'd0);
        bus.irq = 0;
        tick();
        bus.is_retfie = 1; bus.stack_out = 11'h051; bus.gie_wr = 1; bus.gie_din = 0;
        tick();
        chk("retfie.pc", {21'b0, bus.pc}, 32'h051);
        chk("retfie.gie", {31'b0, bus.gie}, 32'd1);
        tick();
        bus.gie_wr = 1; bus.gie_din = 0;
        tick();

        for (int i = 0; i < 16; i++) begin
            bus.is_call = 1; bus.k11 = 11'h200 + 11'(i);
            tick();
            tick();
        end
        chk("ovf.before", {31'b0, bus.stkovf}, 32'd0);
        bus.is_call = 1; bus.k11 = 11'h300;
        #1;
`ifdef STACK_FAULT_RESET_EN
        chk("ovf.push", {31'b0, bus.push}, 32'd0);
        tick();
        chk("ovf.pc", {21'b0, bus.pc}, 32'h000);
        chk("ovf.flush", {31'b0, bus.flush}, 32'd1);
`else
        chk("ovf.push", {31'b0, bus.push}, 32'd1);
        tick();
        chk("ovf.pc", {21'b0, bus.pc}, 32'h300);
`endif
        chk("ovf.flag", {31'b0, bus.stkovf}, 32'd1);
        tick();

`ifndef STACK_FAULT_RESET_EN
        for (int i = 0; i < 16; i++) begin
            bus.is_return = 1; bus.stack_out = 11'h100;
            tick();
            tick();
        end
`endif
        chk("unf.before", {31'b0, bus.stkunf}, 32'd0);
        bus.is_return = 1; bus.stack_out = 11'h2AA; bus.flag_clr = 1;
        #1;
`ifdef STACK_FAULT_RESET_EN
        chk("unf.pop", {31'b0, bus.pop}, 32'd0);
        tick();
        chk("unf.pc", {21'b0, bus.pc}, 32'h000);
`else
        chk("unf.pop", {31'b0, bus.pop}, 32'd1);
        tick();
        chk("unf.pc", {21'b0, bus.pc}, 32'h2AA);
`endif
        chk("unf.flag", {31'b0, bus.stkunf}, 32'd1);
        chk("unf.ovf_cleared", {31'b0, bus.stkovf}, 32'd0);
        tick();
        bus.flag_clr = 1;
        tick();
        chk("clr.flags", {30'b0, bus.stkovf, bus.stkunf}, 32'd0);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/call_return_ctrl.md
# call_return_ctrl

Program-counter and call/return sequencer for the PIC16F1826 core. It decides the next fetch address each cycle and drives the push/pop side of the 16-entry, 11-bit hardware return stack. It handles CALL, CALLW, GOTO, BRA, BRW, RETURN, RETLW, RETFIE, skips and interrupt entry. It also tracks stack depth to raise the sticky STKOVF/STKUNF status bits.

## Interface
- RESET_VEC, 11'h000, address loaded into `pc` on reset
- IRQ_VEC, 11'h004, interrupt entry address
- clk  input  1  core clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- is_call / is_callw / is_goto / is_bra / is_brw  input  1 each  decoded op in execute slot, at most one high
- is_return / is_retlw / is_retfie  input  1 each  decoded return ops
- skip  input  1  executing skip instruction resolved true
- k11  input  11  CALL/GOTO literal
- bra_off  input  9  BRA signed offset
- w  input  8  W register
- pclath  input  3  PCLATH[2:0] for CALLW upper bits
- irq  input  1  level interrupt request
- gie_wr, gie_din  input  1 each  software write to INTCON.GIE
- flag_clr  input  1  clears stkovf/stkunf
- stack_out  input  11  top-of-stack from stack block
- pc  output  11  fetch address
- flush  output  1  instruction now in execute slot is discarded (forced NOP)
- push, pop  output  1 each  stack controls, never both high
- stack_in  output  11  return address to push
- gie  output  1  global interrupt enable
- stkovf, stkunf  output  1 each  sticky fault flags

## Operation
- Two-slot model: instruction fetched at `pc` executes next cycle; during execute, `pc` = executing address + 1.
- Decode inputs and irq are ignored while `flush`=1.
- Normal/skip op: pc <= pc+1. Skip additionally sets flush for the next cycle.
- GOTO: pc <= k11. CALL: push, stack_in=pc, pc <= k11. CALLW: push, stack_in=pc, pc <= {pclath, w}.
- BRA: pc <= pc + sign_ext(bra_off), mod 2^11. BRW: pc <= pc + zero_ext(w), mod 2^11.
- RETURN/RETLW: pop, pc <= stack_out. RETFIE: same, and gie <= 1.
- Every taken transfer sets flush for exactly one cycle.
- Interrupt: sampled when irq & gie & !flush and no transfer op executing. Current ordinary op completes. Then push with stack_in=pc, pc <= IRQ_VEC, gie <= 0, flush.
- If a transfer op is executing, the interrupt defers until the first non-flush slot after it.
- gie_wr loads gie <= gie_din. Interrupt entry clear and RETFIE set both override gie_wr in the same cycle.
- Depth counter 0..16: +1 on push, -1 on pop.
- Push at depth 16: stkovf <= 1, push still issued, depth stays 16.
- Pop at depth 0: stkunf <= 1, pop still issued, pc <= stack_out, depth stays 0.
- flag_clr clears both flags; a new fault in the same cycle wins.

## Timing
- Reset (async): pc=RESET_VEC, flush=1, gie=0, depth=0, stkovf=stkunf=0, push=pop=0, stack_in=0.
- First instruction executes in the second cycle after rst deassertion.
- push/pop/stack_in are combinational in the execute cycle; stack updates on that same edge.
- stack_out is read combinationally in the RETURN cycle.
- pc, flush, gie, depth and flags are registered with 1-cycle latency.
- Each transfer costs 2 cycles; back-to-back transfers are impossible because of the flush slot.
- rst mid-transfer aborts the transfer; no push/pop is completed after the async reset asserts.

## Configuration
- STACK_FAULT_RESET_EN defined: a fault cycle suppresses push/pop and loads pc <= RESET_VEC, flush=1, depth <= 0, gie <= 0. Flags are still set.
- Undefined: faults only set the sticky flags, as described in Operation.

## Test plan
- Reset, then free-run with no ops -> pc sequence 0,1,2,3; flush high only in first cycle.
- CALL k11=0x123 at pc=0x011 -> push=1, stack_in=0x011, next pc=0x123, flush=1; then RETURN with stack_out=0x011 -> pop=1, pc=0x011.
- BRA bra_off=9'h1FE at pc=0x005 -> pc=0x003. BRW w=0xFF at pc=0x7FF -> pc=0x0FE (wrap).
- gie=1, irq raised during GOTO -> GOTO taken, flush cycle, then push stack_in=target+1, pc=0x004, gie=0. RETFIE -> gie=1.
- 17 consecutive CALLs -> stkovf=1 on the 17th, depth stays 16. RETURN at depth 0 -> stkunf=1. flag_clr -> both 0.
- With STACK_FAULT_RESET_EN: 17th CALL -> push=0, pc=0x000, flush=1, stkovf=1.
